// File: rtl/wm_apb_loader_if.sv
// Source word stream plus APB write bus shared by the loader (master) and the
// watermark core / source (slave side).
interface wm_apb_loader_if #(
   parameter int Amba_Word       = 16,
   parameter int Amba_Addr_Depth = 20
);
   logic                     src_valid;
   logic [Amba_Word-1:0]     src_data;
   logic                     src_ready;
   logic                     PSEL;
   logic                     PENABLE;
   logic                     PWRITE;
   logic [Amba_Addr_Depth:0] PADDR;
   logic [Amba_Word-1:0]     PWDATA;
   logic                     PREADY;
   logic                     PSLVERR;

   modport master (
      input  src_valid, src_data, PREADY, PSLVERR,
      output src_ready, PSEL, PENABLE, PWRITE, PADDR, PWDATA
   );
   modport slave (
      output src_valid, src_data, PREADY, PSLVERR,
      input  src_ready, PSEL, PENABLE, PWRITE, PADDR, PWDATA
   );
endinterface

// File: rtl/wm_apb_loader.sv
// APB master that streams parameters, primary and watermark images into the
// watermarking core, kicks it off, then supervises the run until Image_Done.
module wm_apb_loader #(
   parameter int Amba_Word       = 16,
   parameter int Amba_Addr_Depth = 20,
   parameter int Data_Depth      = 8,
   parameter int Num_Params      = 9,
   parameter int Start_Data      = 1,
   parameter int Timeout_Cycles  = 2**20
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            cfg_start,
   input  logic [8:0]      cfg_Np,
   input  logic [8:0]      cfg_Nw,
   wm_apb_loader_if.master bus,
   input  logic            new_pixel,
   input  logic            Image_Done,
   output logic            busy,
   output logic            done,
   output logic [1:0]      err_code,
   output logic [17:0]     pixel_count
);
   localparam int AW  = Amba_Addr_Depth + 1;
   localparam int WDW = $clog2(Timeout_Cycles + 1);

   // Pixels travel inside source words, so they must fit in one.
   if (Data_Depth > Amba_Word) begin : g_bad_depth
      $error("Data_Depth exceeds Amba_Word");
   end

   typedef enum logic [2:0] {
      IDLE, FETCH, SETUP, ACCESS, START_SETUP, START_ACCESS, WAIT_DONE, DONE
   } state_t;

   state_t               state_q, state_d;
   logic [AW-1:0]        addr_q, addr_d, paddr_q, paddr_d;
   logic [Amba_Word-1:0] pwdata_q, pwdata_d;
   logic [18:0]          total_q, total_d;
   logic [17:0]          npsq_q, npsq_d, pix_q, pix_d, pix_nxt, np_sq, nw_sq;
   logic [1:0]           err_q, err_d;
   logic [WDW-1:0]       wd_q, wd_d;
   logic                 done_q, done_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         paddr_q  <= '0;
         pwdata_q <= '0;
         total_q  <= '0;
         npsq_q   <= '0;
         pix_q    <= '0;
         err_q    <= '0;
         wd_q     <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         paddr_q  <= paddr_d;
         pwdata_q <= pwdata_d;
         total_q  <= total_d;
         npsq_q   <= npsq_d;
         pix_q    <= pix_d;
         err_q    <= err_d;
         wd_q     <= wd_d;
         done_q   <= done_d;
      end
   end

   always_comb begin
      np_sq    = 18'(cfg_Np) * 18'(cfg_Np);
      nw_sq    = 18'(cfg_Nw) * 18'(cfg_Nw);
      // A pulse coincident with Image_Done still belongs to this run.
      pix_nxt  = (new_pixel && pix_q != '1) ? pix_q + 18'd1 : pix_q;
      state_d  = state_q;
      addr_d   = addr_q;
      paddr_d  = paddr_q;
      pwdata_d = pwdata_q;
      total_d  = total_q;
      npsq_d   = npsq_q;
      pix_d    = pix_q;
      err_d    = err_q;
      wd_d     = wd_q;
      done_d   = 1'b0;
      case (state_q)
         IDLE: if (cfg_start) begin
            npsq_d  = np_sq;
            total_d = 19'(Num_Params) + 19'(np_sq) + 19'(nw_sq);
            addr_d  = AW'(1);
            err_d   = '0;
            pix_d   = '0;
            state_d = FETCH;
            if (total_d == '0) begin
               state_d  = START_SETUP;
               paddr_d  = '0;
               pwdata_d = Amba_Word'(Start_Data);
            end
         end
         FETCH: if (bus.src_valid) begin
            pwdata_d = bus.src_data;
            paddr_d  = addr_q;
            state_d  = SETUP;
         end
         SETUP: state_d = ACCESS;
         ACCESS: if (bus.PREADY) begin
            if (bus.PSLVERR && err_q == 2'd0) err_d = 2'd1;
            addr_d = addr_q + 1'b1;
            // addr_q is the word just written; addresses run 1..total.
            if (32'(addr_q) < 32'(total_q)) begin
               state_d = FETCH;
            end else begin
               state_d  = START_SETUP;
               paddr_d  = '0;
               pwdata_d = Amba_Word'(Start_Data);
            end
         end
         START_SETUP: state_d = START_ACCESS;
         START_ACCESS: if (bus.PREADY) begin
            if (bus.PSLVERR && err_q == 2'd0) err_d = 2'd1;
            wd_d    = '0;
            state_d = WAIT_DONE;
         end
         WAIT_DONE: begin
            pix_d = pix_nxt;
            if (Image_Done) begin
               if (err_q == 2'd0 && pix_nxt != npsq_q) err_d = 2'd2;
               state_d = DONE;
            end else if (wd_q == WDW'(Timeout_Cycles - 1)) begin
               if (err_q == 2'd0) err_d = 2'd3;
               state_d = DONE;
            end else begin
               wd_d = wd_q + 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
            done_d  = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   // Bus strobes decode straight from state so reset drops them immediately.
   assign bus.PSEL      = (state_q == SETUP) || (state_q == ACCESS) ||
                          (state_q == START_SETUP) || (state_q == START_ACCESS);
   assign bus.PENABLE   = (state_q == ACCESS) || (state_q == START_ACCESS);
   assign bus.PWRITE    = bus.PSEL;
   assign bus.PADDR     = paddr_q;
   assign bus.PWDATA    = pwdata_q;
   assign bus.src_ready = (state_q == FETCH);
   assign busy          = (state_q != IDLE);
   assign done          = done_q;
   assign err_code      = err_q;
   assign pixel_count   = pix_q;
endmodule

// File: tb/tb_wm_apb_loader.sv
// Directed bench for wm_apb_loader: APB slave/source models plus per-scenario tasks.
`timescale 1ns/1ps
module tb_wm_apb_loader;
   localparam int AW = 16, AD = 20, NPAR = 9, TMO = 100;

   logic        clk = 1'b0, rst = 1'b1, cfg_start = 1'b0;
   logic        new_pixel = 1'b0, Image_Done = 1'b0;
   logic [8:0]  cfg_Np = '0, cfg_Nw = '0;
   logic        busy, done;
   logic [1:0]  err_code;
   logic [17:0] pixel_count;

   wm_apb_loader_if #(.Amba_Word(AW), .Amba_Addr_Depth(AD)) bus ();

   wm_apb_loader #(
      .Amba_Word(AW), .Amba_Addr_Depth(AD), .Data_Depth(8),
      .Num_Params(NPAR), .Start_Data(1), .Timeout_Cycles(TMO)
   ) dut (
      .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_Np(cfg_Np), .cfg_Nw(cfg_Nw),
      .bus(bus), .new_pixel(new_pixel), .Image_Done(Image_Done),
      .busy(busy), .done(done), .err_code(err_code), .pixel_count(pixel_count)
   );

   always #5 clk = ~clk;

   int nchk = 0, nerr = 0;
   logic [15:0] words    [0:63];
   logic [20:0] exp_addr [0:63];
   logic [15:0] exp_data [0:63];
   logic [20:0] log_addr [0:63];
   logic [15:0] log_data [0:63];
   int exp_n = 0, src_n = 0;
   int gap_idx = -1, stall_addr = -1, err_addr = -1;
   int src_idx = 0, gap_cnt = 0, xfer_cnt = 0, wait_cnt = 0;
   int stall_cyc = 0, stab_bad = 0, gap_psel = 0, gap_low = 0;
   logic src_en = 1'b0, mon_clr = 1'b0, got_done = 1'b0;
   logic [15:0] stall_word;

   assign stall_word = words[6'(stall_addr - 1)];

   // Source and APB slave models
   always_comb begin
      bus.src_valid = src_en && (src_idx < src_n) && !(src_idx == gap_idx && gap_cnt < 5);
      bus.src_data  = words[src_idx[5:0]];
      bus.PREADY    = !(bus.PSEL && bus.PENABLE && 32'(bus.PADDR) == stall_addr && wait_cnt < 3);
      bus.PSLVERR   = bus.PSEL && bus.PENABLE && 32'(bus.PADDR) == err_addr;
   end

   always @(posedge clk) begin
      if (mon_clr) begin
         src_idx <= 0; gap_cnt <= 0; xfer_cnt <= 0; wait_cnt <= 0;
         stall_cyc <= 0; stab_bad <= 0; gap_psel <= 0; gap_low <= 0;
      end else begin
         if (bus.src_valid && bus.src_ready) src_idx <= src_idx + 1;
         if (src_idx == gap_idx && !bus.src_valid) begin
            gap_cnt <= gap_cnt + 1;
            if (xfer_cnt == gap_idx) begin
               gap_low <= gap_low + 1;
               if (bus.PSEL) gap_psel <= gap_psel + 1;
            end
         end
         if (bus.PSEL && bus.PENABLE && bus.PREADY) begin
            log_addr[xfer_cnt[5:0]] <= bus.PADDR;
            log_data[xfer_cnt[5:0]] <= bus.PWDATA;
            xfer_cnt <= xfer_cnt + 1;
         end
         if (bus.PSEL && bus.PENABLE && !bus.PREADY) begin
            stall_cyc <= stall_cyc + 1;
            if (32'(bus.PADDR) == stall_addr) wait_cnt <= wait_cnt + 1;
            if (32'(bus.PADDR) != stall_addr || bus.PWDATA != stall_word) stab_bad <= stab_bad + 1;
         end
      end
   end

   task automatic start_load(input int np, input int nw);
      exp_n = NPAR + np * np + nw * nw + 1;
      for (int i = 0; i < 64; i++) begin
         exp_addr[i] = (i < exp_n - 1) ? 21'(i + 1) : 21'd0;
         exp_data[i] = (i < exp_n - 1) ? words[i] : 16'd1;
      end
      src_n = exp_n - 1;
      @(negedge clk); mon_clr = 1'b1;
      @(negedge clk); mon_clr = 1'b0;
      cfg_Np = 9'(np); cfg_Nw = 9'(nw); cfg_start = 1'b1; src_en = 1'b1;
      @(negedge clk); cfg_start = 1'b0;
   endtask

   // Noise mode holds new_pixel high and fires a stray cfg_start mid-load.
   task automatic run_load(input int np, input int nw, input bit noise);
      int k;
      start_load(np, nw);
      k = 0;
      while (xfer_cnt < exp_n && k < 2000) begin
         new_pixel = noise;
         cfg_start = noise && (k == 10);
         if (noise && k == 10) cfg_Np = 9'd2;
         @(negedge clk); k++;
      end
      new_pixel = 1'b0; cfg_start = 1'b0; src_en = 1'b0;
   endtask

   task automatic finish_run(input int npix, input bit overlap);
      for (int i = 0; i < npix; i++) begin
         new_pixel = 1'b1; @(negedge clk);
         new_pixel = 1'b0; @(negedge clk);
      end
      Image_Done = 1'b1; new_pixel = overlap; @(negedge clk);
      Image_Done = 1'b0; new_pixel = 1'b0;
      got_done = 1'b0;
      for (int i = 0; i < 10 && !got_done; i++) begin
         if (done) got_done = 1'b1;
         else @(negedge clk);
      end
   endtask

   task automatic test_reset;
      @(negedge clk);
      nchk++; if ({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.src_ready, busy, done} !== 6'b0) begin
         nerr++; $display("FAIL reset_ctl: got %b want 000000", {bus.PSEL, bus.PENABLE, bus.PWRITE, bus.src_ready, busy, done}); end
      nchk++; if (bus.PADDR !== 21'd0 || bus.PWDATA !== 16'd0) begin
         nerr++; $display("FAIL reset_bus: got addr %0d data %0d want 0 0", bus.PADDR, bus.PWDATA); end
      nchk++; if (err_code !== 2'd0 || pixel_count !== 18'd0) begin
         nerr++; $display("FAIL reset_stat: got err %0d pix %0d want 0 0", err_code, pixel_count); end
      rst = 1'b0;
   endtask

   task automatic test_basic;
      run_load(4, 4, 1'b0);
      nchk++; if (xfer_cnt !== exp_n) begin nerr++; $display("FAIL basic_cnt: got %0d want %0d", xfer_cnt, exp_n); end
      for (int i = 0; i < exp_n; i++) begin
         nchk++; if (log_addr[i] !== exp_addr[i] || log_data[i] !== exp_data[i]) begin nerr++;
            $display("FAIL basic_log[%0d]: got %0d/%0d want %0d/%0d", i, log_addr[i], log_data[i], exp_addr[i], exp_data[i]); end
      end
      finish_run(16, 1'b0);
      nchk++; if (got_done !== 1'b1) begin nerr++; $display("FAIL basic_done: got %b want 1", got_done); end
      nchk++; if (err_code !== 2'd0 || pixel_count !== 18'd16 || busy !== 1'b0) begin nerr++;
         $display("FAIL basic_stat: got err %0d pix %0d busy %b want 0 16 0", err_code, pixel_count, busy); end
      @(negedge clk);
      nchk++; if (done !== 1'b0) begin nerr++; $display("FAIL basic_done_pulse: got %b want 0", done); end
   endtask

   task automatic test_wait_states;
      stall_addr = 12;
      run_load(4, 4, 1'b0);
      stall_addr = -1;
      nchk++; if (stall_cyc !== 3 || stab_bad !== 0) begin nerr++;
         $display("FAIL wait_stall: got %0d cycles %0d unstable want 3 0", stall_cyc, stab_bad); end
      for (int i = 0; i < exp_n; i++) begin
         nchk++; if (log_addr[i] !== exp_addr[i] || log_data[i] !== exp_data[i]) begin nerr++;
            $display("FAIL wait_log[%0d]: got %0d/%0d want %0d/%0d", i, log_addr[i], log_data[i], exp_addr[i], exp_data[i]); end
      end
      finish_run(16, 1'b0);
      nchk++; if (got_done !== 1'b1 || err_code !== 2'd0) begin nerr++;
         $display("FAIL wait_stat: got done %b err %0d want 1 0", got_done, err_code); end
   endtask

   task automatic test_src_gap;
      gap_idx = 20;
      run_load(4, 4, 1'b0);
      gap_idx = -1;
      nchk++; if (gap_low !== 3 || gap_psel !== 0) begin nerr++;
         $display("FAIL gap_idle: got %0d idle %0d psel want 3 0", gap_low, gap_psel); end
      for (int i = 0; i < exp_n; i++) begin
         nchk++; if (log_addr[i] !== exp_addr[i] || log_data[i] !== exp_data[i]) begin nerr++;
            $display("FAIL gap_log[%0d]: got %0d/%0d want %0d/%0d", i, log_addr[i], log_data[i], exp_addr[i], exp_data[i]); end
      end
      finish_run(16, 1'b0);
      nchk++; if (err_code !== 2'd0 || pixel_count !== 18'd16) begin nerr++;
         $display("FAIL gap_stat: got err %0d pix %0d want 0 16", err_code, pixel_count); end
   endtask

   task automatic test_slverr;
      err_addr = 5;
      run_load(4, 4, 1'b0);
      err_addr = -1;
      nchk++; if (xfer_cnt !== exp_n || err_code !== 2'd1) begin nerr++;
         $display("FAIL slverr_load: got %0d xfers err %0d want %0d 1", xfer_cnt, err_code, exp_n); end
      finish_run(16, 1'b0);
      nchk++; if (err_code !== 2'd1 || pixel_count !== 18'd16) begin nerr++;
         $display("FAIL slverr_stat: got err %0d pix %0d want 1 16", err_code, pixel_count); end
   endtask

   task automatic test_mismatch;
      run_load(4, 4, 1'b0);
      finish_run(15, 1'b0);
      nchk++; if (got_done !== 1'b1 || err_code !== 2'd2 || pixel_count !== 18'd15) begin nerr++;
         $display("FAIL mismatch_stat: got done %b err %0d pix %0d want 1 2 15", got_done, err_code, pixel_count); end
   endtask

   task automatic test_noise_overlap;
      run_load(4, 4, 1'b1);
      nchk++; if (xfer_cnt !== exp_n || pixel_count !== 18'd0) begin nerr++;
         $display("FAIL noise_load: got %0d xfers pix %0d want %0d 0", xfer_cnt, pixel_count, exp_n); end
      for (int i = 0; i < exp_n; i++) begin
         nchk++; if (log_addr[i] !== exp_addr[i] || log_data[i] !== exp_data[i]) begin nerr++;
            $display("FAIL noise_log[%0d]: got %0d/%0d want %0d/%0d", i, log_addr[i], log_data[i], exp_addr[i], exp_data[i]); end
      end
      finish_run(15, 1'b1);
      nchk++; if (err_code !== 2'd0 || pixel_count !== 18'd16) begin nerr++;
         $display("FAIL overlap_stat: got err %0d pix %0d want 0 16", err_code, pixel_count); end
   endtask

   task automatic test_skip_image;
      run_load(0, 2, 1'b0);
      nchk++; if (xfer_cnt !== 14) begin nerr++; $display("FAIL skip_cnt: got %0d want 14", xfer_cnt); end
      for (int i = 0; i < exp_n; i++) begin
         nchk++; if (log_addr[i] !== exp_addr[i] || log_data[i] !== exp_data[i]) begin nerr++;
            $display("FAIL skip_log[%0d]: got %0d/%0d want %0d/%0d", i, log_addr[i], log_data[i], exp_addr[i], exp_data[i]); end
      end
      finish_run(0, 1'b0);
      nchk++; if (got_done !== 1'b1 || err_code !== 2'd0 || pixel_count !== 18'd0) begin nerr++;
         $display("FAIL skip_stat: got done %b err %0d pix %0d want 1 0 0", got_done, err_code, pixel_count); end
   endtask

   task automatic test_timeout;
      int n;
      run_load(4, 4, 1'b0);
      n = 0;
      while (!done && n < 300) begin @(negedge clk); n++; end
      nchk++; if (n !== 101) begin nerr++; $display("FAIL timeout_cycles: got %0d want 101", n); end
      nchk++; if (err_code !== 2'd3 || pixel_count !== 18'd0) begin nerr++;
         $display("FAIL timeout_stat: got err %0d pix %0d want 3 0", err_code, pixel_count); end
   endtask

   task automatic test_reset_mid;
      logic found;
      found = 1'b0;
      start_load(4, 4);
      for (int k = 0; k < 500 && !found; k++) begin
         if (bus.PSEL && bus.PENABLE && bus.PADDR == 21'd30) found = 1'b1;
         else @(negedge clk);
      end
      nchk++; if (found !== 1'b1) begin nerr++; $display("FAIL rstmid_reach: got %b want 1", found); end
      rst = 1'b1;
      #1;
      nchk++; if ({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.src_ready, busy, done} !== 6'b0) begin
         nerr++; $display("FAIL rstmid_ctl: got %b want 000000", {bus.PSEL, bus.PENABLE, bus.PWRITE, bus.src_ready, busy, done}); end
      nchk++; if (bus.PADDR !== 21'd0 || bus.PWDATA !== 16'd0 || err_code !== 2'd0 || pixel_count !== 18'd0) begin nerr++;
         $display("FAIL rstmid_regs: got addr %0d data %0d err %0d pix %0d want 0 0 0 0", bus.PADDR, bus.PWDATA, err_code, pixel_count); end
      src_en = 1'b0;
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      run_load(4, 4, 1'b0);
      for (int i = 0; i < exp_n; i++) begin
         nchk++; if (log_addr[i] !== exp_addr[i] || log_data[i] !== exp_data[i]) begin nerr++;
            $display("FAIL rstmid_log[%0d]: got %0d/%0d want %0d/%0d", i, log_addr[i], log_data[i], exp_addr[i], exp_data[i]); end
      end
      finish_run(16, 1'b0);
      nchk++; if (err_code !== 2'd0 || pixel_count !== 18'd16) begin nerr++;
         $display("FAIL rstmid_stat: got err %0d pix %0d want 0 16", err_code, pixel_count); end
   endtask

   initial begin
      words[0] = 16'd255; words[1] = 16'd4;  words[2] = 16'd4;
      words[3] = 16'd2;   words[4] = 16'd20; words[5] = 16'd83;
      words[6] = 16'd96;  words[7] = 16'd25; words[8] = 16'd31;
      for (int i = 9; i < 64; i++) words[i] = 16'(i * 7 + 100);
      test_reset;
      test_basic;
      test_wait_states;
      test_src_gap;
      test_slverr;
      test_mismatch;
      test_noise_overlap;
      test_skip_image;
      test_timeout;
      test_reset_mid;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
      $finish;
   end
endmodule

// File: doc/wm_apb_loader.md
Name: wm_apb_loader

Overview:
- Synthesizable APB master that replaces bench-driven loading of the Visibal_Watermarking core.
- Takes the parameter words, then the primary image, then the watermark image, from a valid/ready source stream. Writes them over a full two-phase APB protocol with PREADY and PSLVERR support, then issues the start write.
- Supervises the run: counts new_pixel pulses until Image_Done, then reports status.
- Generalises the fixed 9-parameter, zero-wait-state loading sequence with a parametrised parameter count, start address/data, wait states, error reporting and a watchdog.

Parameters:
- Amba_Word, 16, APB data width.
- Amba_Addr_Depth, 20, PADDR is Amba_Addr_Depth+1 bits wide.
- Data_Depth, 8, pixel bit depth.
- Num_Params, 9, parameter words written at addresses 1..Num_Params.
- Start_Data, 1, value written to address 0 to launch the core.
- Timeout_Cycles, 2**20, maximum WAIT_DONE cycles before the timeout error.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cfg_start  in  1  one-cycle request to begin a load; honoured only in IDLE.
- cfg_Np  in  9  primary image side length.
- cfg_Nw  in  9  watermark side length.
- src_valid  in  1  source word valid.
- src_data  in  Amba_Word  source word.
- src_ready  out  1  source word accepted when src_valid && src_ready.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB write; always 1 while PSEL is high.
- PADDR  out  Amba_Addr_Depth+1  APB address.
- PWDATA  out  Amba_Word  APB write data.
- PREADY  in  1  slave ready; tie to 1 for the current core.
- PSLVERR  in  1  slave error, sampled with PREADY.
- new_pixel  in  1  one-cycle pulse per output pixel from the core.
- Image_Done  in  1  core finished, level or pulse.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on entering IDLE from DONE.
- err_code  out  2  0 ok, 1 PSLVERR seen, 2 pixel-count mismatch, 3 timeout.
- pixel_count  out  18  new_pixel pulses counted in the current run.

Behaviour:
- Reset: state=IDLE. All outputs 0: PSEL, PENABLE, PWRITE, PADDR, PWDATA, src_ready, busy, done, err_code, pixel_count.
- Reset mid-operation: abandons any transfer immediately; PSEL/PENABLE drop asynchronously.
- IDLE, on cfg_start:
  - Latch Np, Nw.
  - total = Num_Params + Np*Np + Nw*Nw, computed at 19 bits.
  - addr=1; clear err_code and pixel_count.
  - Go to FETCH, or to START_SETUP if total==0.
- FETCH:
  - src_ready=1 only in this state.
  - On handshake: PWDATA <= src_data, PADDR <= addr, go to SETUP.
  - No handshake: stay; bus idle (PSEL=0).
- SETUP: PSEL=1, PWRITE=1, PENABLE=0 for exactly one cycle, then ACCESS.
- ACCESS:
  - PSEL=1, PENABLE=1; hold PADDR/PWDATA until PREADY=1.
  - On PREADY: if PSLVERR, err_code <= 1 (sticky; first error wins; load continues).
  - Then addr++; go to FETCH if addr < total, else START_SETUP.
  - Minimum 3 cycles per word.
- Address map: params at 1..Num_Params; primary at Num_Params+1..Num_Params+Np*Np; watermark immediately after.
  - Np==0 or Nw==0 skips that image with no gap in addresses.
  - Word order is fixed; the block does not interpret data contents.
- START_SETUP/START_ACCESS: same two-phase write with PADDR=0, PWDATA=Start_Data. Then WAIT_DONE with PSEL=PENABLE=0.
- WAIT_DONE:
  - pixel_count increments on each new_pixel, saturating at 2^18-1.
  - new_pixel in the same cycle as Image_Done is counted.
  - On Image_Done: if err_code==0 and pixel_count_final != Np*Np, err_code <= 2. Go to DONE.
  - Watchdog: WAIT_DONE cycle counter reaching Timeout_Cycles sets err_code <= 3 (if 0) and goes to DONE.
- DONE: one cycle; then IDLE with done=1 for that cycle. err_code and pixel_count hold until the next cfg_start.
- cfg_start outside IDLE is ignored. new_pixel outside WAIT_DONE is ignored.

Test Plan:
- Np=Nw=4, source words 255,4,4,2,20,83,96,25,31 then 16 primary and 16 watermark words, PREADY=1:
  - 41 writes at addrs 1..41 in order, then addr 0 data 1.
  - 16 new_pixel pulses then Image_Done -> done pulse, err_code=0, pixel_count=16.
- Same load with PREADY low 3 cycles on addr 12 -> PADDR/PWDATA stable through the wait; sequence otherwise identical.
- src_valid deasserted 5 cycles after word 20 -> PSEL=0 during the gap; addr 21 follows with correct data.
- PSLVERR=1 on addr 5 -> load completes, err_code=1, stays 1 despite 16 correct pixels.
- Np=4 with only 15 new_pixel pulses before Image_Done -> err_code=2, pixel_count=15. Separately, no Image_Done with Timeout_Cycles=100 -> err_code=3 after 100 cycles.
- rst asserted in ACCESS at addr 30 -> all outputs 0 asynchronously; a new cfg_start restarts at addr 1.
